// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } AdderState;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell reused by the serial adder datapath.
module FullAdder (
   input  logic A,
   input  logic B,
   input  logic Cin,
   output logic Sum,
   output logic Carry
);

   assign Sum   = A ^ B ^ Cin;
   assign Carry = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one operand bit per clock, LSB first, through a
// single full adder whose carry is held in a flip-flop between bits.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   AdderState        r_state;
   AdderState        w_nextState;
   logic [WIDTH-1:0] r_aSr;
   logic [WIDTH-1:0] r_bSr;
   logic [WIDTH-2:0] r_partial;
   logic             r_carry;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] w_shifted;
   logic             w_faSum;
   logic             w_faCarry;
   logic             w_load;
   logic             w_shift;
   logic             w_lastBit;

   FullAdder u_fullAdder (
      .A     (r_aSr[0]),
      .B     (r_bSr[0]),
      .Cin   (r_carry),
      .Sum   (w_faSum),
      .Carry (w_faCarry)
   );

   assign w_lastBit = (r_count == LAST_BIT);
   // The newest sum bit enters at the MSB; after the last bit this is the full result.
   assign w_shifted = {w_faSum, r_partial};
   assign Busy      = (r_state == RUN);
   assign Done      = (r_state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      case (r_state)
         IDLE: begin
            if (Start) begin
               w_load      = 1'b1;
               w_nextState = RUN;
            end
         end
         RUN: begin
            w_shift = 1'b1;
            if (w_lastBit) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            if (Start) begin
               w_load      = 1'b1;
               w_nextState = RUN;
            end else begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Sum/Cout only update on the completion edge so they hold the last result otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_aSr     <= '0;
         r_bSr     <= '0;
         r_partial <= '0;
         r_carry   <= 1'b0;
         r_count   <= '0;
         Sum       <= '0;
         Cout      <= 1'b0;
      end else if (w_load) begin
         r_aSr   <= A;
         r_bSr   <= B;
         r_carry <= Cin;
         r_count <= '0;
      end else if (w_shift) begin
         r_aSr     <= r_aSr >> 1;
         r_bSr     <= r_bSr >> 1;
         r_partial <= w_shifted[WIDTH-1:1];
         r_carry   <= w_faCarry;
         r_count   <= r_count + CW'(1);
         if (w_lastBit) begin
            Sum  <= w_shifted;
            Cout <= w_faCarry;
         end
      end
   end

endmodule
